// File: rtl/dmem_pkg.sv
// Shared constants and address-decode helpers for the SigmaCore data memory.
package dmem_pkg;

  localparam int unsigned DMEM_DATA_W    = 32;
  localparam int unsigned DMEM_DEPTH_DEF = 1024;

  // Word index of a byte address; the byte offset addr[1:0] is discarded.
  function automatic logic [31:0] dmem_idx(input logic [31:0] addr, input int unsigned idx_w);
    logic [31:0] mask;
    mask = (32'd1 << idx_w) - 32'd1;
    return (addr >> 2) & mask;
  endfunction

  // True when no address bit above the word index is set (no wrap-around).
  function automatic logic dmem_in_range(input logic [31:0] addr, input int unsigned idx_w);
    return (addr >> (idx_w + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Load/store bus between the MEM stage and the data memory.
// err_out exists only when DATA_MEMORY_ERR_EN is defined.
interface data_memory_if;

  logic [31:0] addr_in;
  logic [31:0] write_data_in;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] read_data_out;
`ifdef DATA_MEMORY_ERR_EN
  logic        err_out;

  modport master (
    output addr_in, write_data_in, write_enable, read_enable,
    input  read_data_out, err_out
  );
  modport slave (
    input  addr_in, write_data_in, write_enable, read_enable,
    output read_data_out, err_out
  );
`else
  modport master (
    output addr_in, write_data_in, write_enable, read_enable,
    input  read_data_out
  );
  modport slave (
    input  addr_in, write_data_in, write_enable, read_enable,
    output read_data_out
  );
`endif

endinterface

// File: rtl/dmem_ram_array.sv
// Plain single-port synchronous RAM, read-before-write, written in an inferable form.
module dmem_ram_array #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned DataW = 32,
  localparam int unsigned IdxW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [IdxW-1:0]  idx,
  input  logic [DataW-1:0] wdata,
  output logic [DataW-1:0] rdata
);

  logic [DataW-1:0] mem [Depth];
  logic [DataW-1:0] rdata_q;

  // Nonblocking read of mem returns the pre-write word on a same-index collision.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata_q <= mem[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory.sv
// Word-organised data RAM behind the MEM stage: address decode, range check, output reset.
// Optional registered access-error flag when DATA_MEMORY_ERR_EN is defined.
module data_memory
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_DEF,
  parameter int unsigned DATA_W      = DMEM_DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  data_memory_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic              zero_q;

  always_comb begin
    idx      = IDX_W'(dmem_idx(bus.addr_in, IDX_W));
    in_range = dmem_in_range(bus.addr_in, IDX_W);
    ram_we   = rst_n & bus.write_enable & in_range;
    ram_re   = rst_n & bus.read_enable & in_range;
  end

  dmem_ram_array #(
    .Depth (DEPTH_WORDS),
    .DataW (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (idx),
    .wdata (bus.write_data_in),
    .rdata (ram_rdata)
  );

  // The RAM's own read register has no reset; zero_q masks it after reset or an
  // out-of-range read and both hold together while read_enable is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q <= 1'b1;
    end else if (bus.read_enable) begin
      zero_q <= ~in_range;
    end
  end

  assign bus.read_data_out = zero_q ? '0 : ram_rdata;

`ifdef DATA_MEMORY_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (bus.write_enable | bus.read_enable) & (~in_range | (|bus.addr_in[1:0]));
    end
  end

  assign bus.err_out = err_q;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus random traffic
// against an associative-array memory model.
module tb_data_memory;

  logic clk_tb = 1'b0;
  logic rst_n;

  data_memory_if bus ();

  data_memory dut (
    .clk   (clk_tb),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk_tb = ~clk_tb;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [int];
  logic [31:0] exp_rd;
  logic        exp_err;

  task automatic check_rd(input string tag, input logic [31:0] exp);
    total++;
    assert (bus.read_data_out === exp) else begin
      bad++;
      $error("FAIL %s: read_data_out=%h expected %h", tag, bus.read_data_out, exp);
    end
  endtask

  task automatic check_err(input string tag, input logic exp);
`ifdef DATA_MEMORY_ERR_EN
    total++;
    assert (bus.err_out === exp) else begin
      bad++;
      $error("FAIL %s: err_out=%b expected %b", tag, bus.err_out, exp);
    end
`endif
  endtask

  // One clock: drive at negedge, predict from the model, check 1 time unit after posedge.
  task automatic step(input string tag, input logic rst, input logic we, input logic re,
                      input logic [31:0] addr, input logic [31:0] wd);
    logic oor;
    int   k;
    @(negedge clk_tb);
    rst_n             = rst;
    bus.write_enable  = we;
    bus.read_enable   = re;
    bus.addr_in       = addr;
    bus.write_data_in = wd;
    oor     = addr >= 32'd4096;
    exp_err = 1'b0;
    if (!rst) begin
      exp_rd = 32'h0;
    end else begin
      k = oor ? 0 : int'(addr / 32'd4);
      if (re) exp_rd = oor ? 32'h0 : model_mem[k];
      if (we && !oor) model_mem[k] = wd;
      exp_err = (we || re) && (oor || (addr % 32'd4) != 32'd0);
    end
    @(posedge clk_tb);
    #1;
    check_rd(tag, exp_rd);
    check_err(tag, exp_err);
  endtask

  initial begin
    logic        r_rst, r_we, r_re;
    logic [31:0] r_addr;
    rst_n             = 1'b0;
    bus.write_enable  = 1'b0;
    bus.read_enable   = 1'b0;
    bus.addr_in       = 32'h0;
    bus.write_data_in = 32'h0;

    step("reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_rd("reset_lit", 32'h0);

    step("wr_100", 1'b1, 1'b1, 1'b0, 32'h100, 32'hCAFEBABE);
    step("wr_000", 1'b1, 1'b1, 1'b0, 32'h000, 32'hA5A5_5A5A);
    step("idle0", 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    step("rd_100", 1'b1, 1'b0, 1'b1, 32'h100, 32'h0);
    check_rd("rd_100_lit", 32'hCAFEBABE);
    step("hold0", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check_rd("hold0_lit", 32'hCAFEBABE);

    step("wr_204", 1'b1, 1'b1, 1'b0, 32'h204, 32'h12345678);
    step("rerd_100", 1'b1, 1'b0, 1'b1, 32'h100, 32'h0);
    check_rd("rerd_100_lit", 32'hCAFEBABE);
    step("rd_204", 1'b1, 1'b0, 1'b1, 32'h204, 32'h0);
    check_rd("rd_204_lit", 32'h12345678);

    step("rbw", 1'b1, 1'b1, 1'b1, 32'h100, 32'h1);
    check_rd("rbw_old_lit", 32'hCAFEBABE);
    step("rbw_new", 1'b1, 1'b0, 1'b1, 32'h100, 32'h0);
    check_rd("rbw_new_lit", 32'h00000001);
    step("rd_103", 1'b1, 1'b0, 1'b1, 32'h103, 32'h0);
    check_rd("rd_103_lit", 32'h00000001);

    step("wr_oor", 1'b1, 1'b1, 1'b0, 32'h0001_0000, 32'hDEADBEEF);
    step("rd_oor", 1'b1, 1'b0, 1'b1, 32'h0001_0000, 32'h0);
    check_rd("rd_oor_lit", 32'h0);
    step("rd_000", 1'b1, 1'b0, 1'b1, 32'h000, 32'h0);
    check_rd("no_wrap_lit", 32'hA5A5_5A5A);

    step("rd_204b", 1'b1, 1'b0, 1'b1, 32'h204, 32'h0);
    step("reset2", 1'b0, 1'b0, 1'b1, 32'h204, 32'h0);
    check_rd("reset2_lit", 32'h0);
    step("post_rst", 1'b1, 1'b0, 1'b1, 32'h204, 32'h0);
    check_rd("post_rst_lit", 32'h12345678);

    for (int i = 0; i < 5; i++) begin
      step("hold_wr", 1'b1, 1'b1, 1'b0, 32'h300 + 32'(i * 4), $urandom);
      check_rd("hold_lit", 32'h12345678);
    end

    // Seed a small pool so random reads never touch unwritten words.
    for (int i = 0; i < 8; i++) step("seed", 1'b1, 1'b1, 1'b0, 32'(i * 4), $urandom);

    for (int i = 0; i < 400; i++) begin
      r_rst = ($urandom % 32) != 0;
      r_we  = 1'($urandom % 2);
      r_re  = 1'($urandom % 2);
      if (($urandom % 8) == 0) r_addr = 32'h1000 + ($urandom % 32'h10000);
      else                     r_addr = ($urandom % 8) * 4 + ($urandom % 4);
      step("rand", r_rst, r_we, r_re, r_addr, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
